// File: rtl/layer0_pkg.sv
// Shared Q4.4 constants, FSM state type and output saturation for the layer-0 datapath.
// Later layers reuse saturate() on their own accumulators.
package layer0_pkg;

    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 4;
    localparam int Z_MAX     = 127;
    localparam int Z_MIN     = -128;
    // Widest accumulator saturate() accepts; callers sign-extend into it.
    localparam int SAT_W     = 32;

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SAT_W-1:0] t);
        if (t > Z_MAX) begin
            return DATA_W'(Z_MAX);
        end
        if (t < Z_MIN) begin
            return DATA_W'(Z_MIN);
        end
        return DATA_W'(t);
    endfunction

endpackage

// File: rtl/layer0_sat_shift.sv
// Rescales a Q8.8-scaled accumulator back to Q4.4 (floor shift) and clamps to the signed output range.
module layer0_sat_shift #(
    parameter int ACC_W     = 20,
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic signed [ACC_W-1:0]  s,
    output logic signed [DATA_W-1:0] z
);
    import layer0_pkg::*;

    logic signed [ACC_W-1:0] t;

    assign t = s >>> FRAC_BITS;
    assign z = saturate(SAT_W'(t));

endmodule

// File: rtl/layer0_neuron_mac.sv
// Sequential MAC neuron: accumulates N_INPUTS x*w products, adds bias on the last pair,
// and holds the saturated Q4.4 result until the activation stage takes it.
module layer0_neuron_mac #(
    parameter int N_INPUTS  = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 20,
    parameter int FRAC_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] z_value,
    output logic                     busy
);
    import layer0_pkg::*;

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          count;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   sum_final;
    logic signed [DATA_W-1:0]  z_next;
    logic                      is_final;

    assign prod      = x_data * w_data;
    assign prod_ext  = ACC_W'(prod);
    // Bias is Q4.4 while products are Q8.8, so align it before adding.
    assign bias_ext  = ACC_W'(bias) <<< FRAC_BITS;
    assign sum_final = acc + prod_ext + bias_ext;
    assign is_final  = (count == CNT_W'(N_INPUTS - 1));

    layer0_sat_shift #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_shift (
        .s (sum_final),
        .z (z_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACC;
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            z_value   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        if (is_final) begin
                            z_value   <= z_next;
                            acc       <= '0;
                            count     <= '0;
                            busy      <= 1'b0;
                            state     <= ST_OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc   <= acc + prod_ext;
                            count <= count + 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer0_neuron_mac.sv
// Directed bench for layer0_neuron_mac with hand-computed Q4.4 results.
module tb_layer0_neuron_mac;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x_data;
    logic signed [7:0] w_data;
    logic signed [7:0] bias;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] z_value;
    logic              busy;

    int n_vec;
    int n_err;

    layer0_neuron_mac #(
        .N_INPUTS  (4),
        .DATA_W    (8),
        .ACC_W     (20),
        .FRAC_BITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_data    (x_data),
        .w_data    (w_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_value   (z_value),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair for exactly one accepting edge; waits (bounded) for in_ready.
    task automatic send_pair(input logic signed [7:0] x, input logic signed [7:0] w,
                             input logic signed [7:0] b);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end
        x_data   = x;
        w_data   = w;
        bias     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic feed4(input logic signed [7:0] x, input logic signed [7:0] w,
                         input logic signed [7:0] b);
        for (int i = 0; i < 4; i++) send_pair(x, w, b);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec += 4;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (z_value !== 8'sd0) begin n_err++; $display("FAIL reset_z: got %0d want 0", z_value); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unity();
        for (int i = 0; i < 3; i++) send_pair(8'sd16, 8'sd16, 8'sd0);
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL unity_early_valid: got %b want 0", out_valid); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL unity_busy: got %b want 1", busy); end
        send_pair(8'sd16, 8'sd16, 8'sd0);
        n_vec += 4;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL unity_latency: out_valid=%b want 1", out_valid); end
        if (z_value !== 8'sd64) begin n_err++; $display("FAIL unity_z: got %0d want 64", z_value); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL unity_in_ready: got %b want 0", in_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL unity_busy_clear: got %b want 0", busy); end
        consume();
    endtask

    task automatic test_bias_and_rounding();
        feed4(8'sd0, 8'sd55, -8'sd5);
        n_vec++;
        if (z_value !== -8'sd5) begin n_err++; $display("FAIL bias_neg: got %0d want -5", z_value); end
        consume();
        feed4(8'sd0, -8'sd3, 8'sd127);
        n_vec++;
        if (z_value !== 8'sd127) begin n_err++; $display("FAIL bias_max: got %0d want 127", z_value); end
        consume();
        // Sum -4 in Q8.8 must floor to -1, not truncate to 0.
        feed4(-8'sd1, 8'sd1, 8'sd0);
        n_vec++;
        if (z_value !== -8'sd1) begin n_err++; $display("FAIL floor_shift: got %0d want -1", z_value); end
        consume();
    endtask

    task automatic test_saturation();
        feed4(8'sd127, 8'sd127, 8'sd0);
        n_vec++;
        if (z_value !== 8'sd127) begin n_err++; $display("FAIL sat_pos: got %0d want 127", z_value); end
        consume();
        feed4(-8'sd128, 8'sd127, 8'sd0);
        n_vec++;
        if (z_value !== -8'sd128) begin n_err++; $display("FAIL sat_neg: got %0d want -128", z_value); end
        consume();
        feed4(-8'sd128, -8'sd128, 8'sd0);
        n_vec++;
        if (z_value !== 8'sd127) begin n_err++; $display("FAIL sat_negneg: got %0d want 127", z_value); end
        consume();
    endtask

    task automatic test_backpressure();
        feed4(8'sd16, 8'sd16, 8'sd0);
        x_data    = 8'sd99;
        w_data    = 8'sd99;
        bias      = 8'sd99;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec += 3;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            if (z_value !== 8'sd64) begin n_err++; $display("FAIL bp_z_stable[%0d]: got %0d want 64", i, z_value); end
        end
        in_valid = 1'b0;
        consume();
        n_vec += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_consume: busy=%b want 0", busy); end
        // 512 - 128 + 15 - 14 + (3<<4) = 433 -> 27
        send_pair(8'sd32, 8'sd16, 8'sd3);
        send_pair(-8'sd16, 8'sd8, 8'sd3);
        send_pair(8'sd5, 8'sd3, 8'sd3);
        send_pair(-8'sd7, 8'sd2, 8'sd3);
        n_vec++;
        if (z_value !== 8'sd27) begin n_err++; $display("FAIL bp_next_result: got %0d want 27", z_value); end
        consume();
    endtask

    task automatic test_gapped();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            out_ready = (i == 3) ? 1'b0 : 1'b1;
            send_pair(8'sd16, 8'sd16, 8'sd0);
            if (i < 3) begin
                n_vec++;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_early[%0d]: got %b want 0", i, out_valid); end
            end
        end
        n_vec += 2;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", out_valid); end
        if (z_value !== 8'sd64) begin n_err++; $display("FAIL gap_z: got %0d want 64", z_value); end
        consume();
    endtask

    task automatic test_reset_mid();
        send_pair(8'sd100, 8'sd100, 8'sd0);
        send_pair(8'sd100, 8'sd100, 8'sd0);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_async_busy: got %b want 0", busy); end
        tick();
        rst = 1'b0;
        tick();
        feed4(8'sd16, 8'sd16, 8'sd0);
        n_vec++;
        if (z_value !== 8'sd64) begin n_err++; $display("FAIL mid_fresh_z: got %0d want 64", z_value); end
        // Asynchronous reset while a result is held: out_valid must drop before the next edge.
        #2 rst = 1'b1;
        #1;
        n_vec += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL out_async_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL out_async_ready: got %b want 1", in_ready); end
        if (z_value !== 8'sd0) begin n_err++; $display("FAIL out_async_z: got %0d want 0", z_value); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_data    = '0;
        w_data    = '0;
        bias      = '0;
        test_reset();
        test_unity();
        test_bias_and_rounding();
        test_saturation();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
